// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the sequential multiply/divide unit
package mult_div_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int ITERATIONS = DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div.sv
// rtl/mult_div.sv - signed shift-add multiplier and restoring divider answering the control unit's ctrl/end handshake
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mult_ctrl,
  input  logic             div_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_end,
  output logic             div_end,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t               state, next_state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     mag;
  logic                 neg_hi, neg_lo, op_div, dz;
  logic                 last, active_ctrl;
  logic [WIDTH-1:0]     a_mag, b_mag, res_hi, res_lo;
  logic [WIDTH:0]       add_sum, shifted;
  logic [WIDTH+1:0]     diff;
  logic                 fits;

  assign a_mag       = a[WIDTH-1] ? -a : a;
  assign b_mag       = b[WIDTH-1] ? -b : b;
  assign active_ctrl = op_div ? div_ctrl : mult_ctrl;
  assign last        = (cnt == CW'(WIDTH - 1));

  // acc holds {partial product, multiplier} for a multiply and {remainder, quotient} for a divide
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag & {WIDTH{acc[0]}}};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, mag};
    fits     = ~|diff[WIDTH+1:WIDTH];
    acc_step = {add_sum, acc[WIDTH-1:1]};
    if (op_div) begin
      if (fits) acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else      acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    res_hi = acc_step[2*WIDTH-1:WIDTH];
    res_lo = acc_step[WIDTH-1:0];
    if (op_div) begin
      if (neg_hi) res_hi = -acc_step[2*WIDTH-1:WIDTH];
      if (neg_lo) res_lo = -acc_step[WIDTH-1:0];
    end else if (neg_lo) begin
      {res_hi, res_lo} = -acc_step;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mult_ctrl)     next_state = MULT_RUN;
        else if (div_ctrl) next_state = (b == '0) ? DONE : DIV_RUN;
      end
      MULT_RUN, DIV_RUN: begin
        if (!active_ctrl) next_state = IDLE;
        else if (last)    next_state = DONE;
      end
      DONE: begin
        if (!active_ctrl) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // end flags rise one edge after DONE is entered, so a zero divisor answers one cycle after acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      mag      <= '0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
      op_div   <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mult_end <= 1'b0;
      div_end  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mult_ctrl) begin
            acc    <= {{WIDTH{1'b0}}, b_mag};
            mag    <= a_mag;
            neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi <= a[WIDTH-1] ^ b[WIDTH-1];
            op_div <= 1'b0;
            dz     <= 1'b0;
          end else if (div_ctrl) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            mag    <= b_mag;
            neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi <= a[WIDTH-1];
            op_div <= 1'b1;
            dz     <= (b == '0);
          end
        end
        MULT_RUN, DIV_RUN: begin
          if (!active_ctrl) begin
            cnt <= '0;
          end else begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last) begin
              hi  <= res_hi;
              lo  <= res_lo;
              cnt <= '0;
            end
          end
        end
        DONE: begin
          if (active_ctrl) begin
            mult_end <= ~op_div;
            div_end  <= op_div;
            div_zero <= dz;
          end else begin
            mult_end <= 1'b0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - scoreboard bench for mult_div with directed multiply/divide vectors
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mult_ctrl = 1'b0;
  logic        div_ctrl = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        mult_end, div_end, div_zero;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          is_div;
    bit          dz;
    int          end_cyc;
  } exp_t;

  exp_t sb[$];

  mult_div dut (
    .clock    (clock),
    .reset    (reset),
    .mult_ctrl(mult_ctrl),
    .div_ctrl (div_ctrl),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .mult_end (mult_end),
    .div_end  (div_end),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit prev_m = 1'b0;
  bit prev_d = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (mult_end || div_end) chk("end_exclusive", 64'(mult_end & div_end), 64'd0);
      if ((mult_end && !prev_m) || (div_end && !prev_d)) begin
        if (sb.size() == 0) begin
          chk("unexpected_end", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("sb_hi", 64'(hi), 64'(e.hi));
          chk("sb_lo", 64'(lo), 64'(e.lo));
          chk("sb_kind", 64'(div_end), 64'(e.is_div));
          chk("sb_div_zero", 64'(div_zero), 64'(e.dz));
          chk("sb_latency", 64'(cyc), 64'(e.end_cyc));
        end
      end
    end
    prev_m = mult_end;
    prev_d = div_end;
  end

  // Called at a negedge; returns at a negedge with the unit back in IDLE
  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit edz, input int lat);
    exp_t e;
    bit   seen;
    e.hi = eh; e.lo = el; e.is_div = !m; e.dz = edz; e.end_cyc = cyc + 1 + lat;
    sb.push_back(e);
    a = av; b = bv; mult_ctrl = m; div_ctrl = d;
    @(negedge clock);
    a = ~av; b = ~bv;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mult_end || div_end) seen = 1;
      else @(negedge clock);
    end
    chk({name, "_done"}, 64'(seen), 64'd1);
    @(negedge clock);
    chk({name, "_hold"}, 64'(m ? mult_end : div_end), 64'd1);
    mult_ctrl = 0; div_ctrl = 0;
    @(negedge clock);
    chk({name, "_clear"}, 64'({mult_end, div_end, div_zero}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_flags", 64'({mult_end, div_end, div_zero}), 64'd0);
    reset = 0;

    run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33);
    run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33);
    run_op("div_zero", 0, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 1);
    run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 33);
    run_op("mul_min_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 33);
    run_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, 33);
    run_op("both_ctrl", 1, 1, 32'd6, 32'd5, 32'h0, 32'd30, 0, 33);

    a = 32'd100; b = 32'd7; div_ctrl = 1;
    repeat (10) @(negedge clock);
    div_ctrl = 0;
    @(negedge clock);
    chk("abort_no_end", 64'({mult_end, div_end}), 64'd0);
    chk("abort_hilo", {hi, lo}, {32'h0, 32'd30});
    run_op("div_after_abort", 0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 33);

    a = 32'd1000; b = 32'd1000; mult_ctrl = 1;
    repeat (15) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1; mult_ctrl = 0;
    #1;
    chk("async_reset_hilo", {hi, lo}, 64'd0);
    chk("async_reset_flags", 64'({mult_end, div_end, div_zero}), 64'd0);
    @(negedge clock);
    reset = 0;
    run_op("mul_3_4", 1, 0, 32'd3, 32'd4, 32'h0, 32'd12, 0, 33);

    repeat (2) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
